// File: rtl/esm_instr_feeder_pkg.sv
// rtl/esm_instr_feeder_pkg.sv - RV32I opcode constants, NOP encoding and opcode classifier for the ESM feeder
package esm_instr_feeder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Two control bits travel with every stored instruction word.
    localparam int DEC_CTRL_W = 2;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_UPPER,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
    } dec_ctrl_t;

    function automatic instr_class_e classify_opcode(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OP_R:              cls = CLS_R;
            OP_I_ALU:          cls = CLS_I_ALU;
            OP_LOAD:           cls = CLS_LOAD;
            OP_STORE:          cls = CLS_STORE;
            OP_BRANCH:         cls = CLS_BRANCH;
            OP_LUI, OP_AUIPC:  cls = CLS_UPPER;
            OP_JAL, OP_JALR:   cls = CLS_JUMP;
            default:           cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic dec_ctrl_t class_ctrl(input instr_class_e cls);
        dec_ctrl_t ctrl;
        case (cls)
            CLS_R:      ctrl = '{alu_src: 1'b0, reg_write: 1'b1};
            CLS_STORE:  ctrl = '{alu_src: 1'b1, reg_write: 1'b0};
            CLS_BRANCH: ctrl = '{alu_src: 1'b0, reg_write: 1'b0};
            CLS_ILLEGAL: ctrl = '{alu_src: 1'b1, reg_write: 1'b0};
            default:    ctrl = '{alu_src: 1'b1, reg_write: 1'b1};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/esm_sync_fifo.sv
// rtl/esm_sync_fifo.sv - Synchronous first-word-fall-through FIFO with count and flush
module esm_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/esm_instr_feeder.sv
// rtl/esm_instr_feeder.sv - Buffers fetched RV32I words, decodes ALUSrc/RegWrite and feeds the ESM core
module esm_instr_feeder
    import esm_instr_feeder_pkg::*;
#(
    parameter int Instr_word_size = 32,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Instr_word_size-1:0] in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Instr_word_size-1:0] out_instr,
    output logic                       out_ALUSrc,
    output logic                       out_RegWrite,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       illegal_seen
);

    localparam int ENTRY_W = Instr_word_size + DEC_CTRL_W;

    instr_class_e               dec_cls;
    dec_ctrl_t                  dec_ctrl;
    logic [Instr_word_size-1:0] dec_instr;
    logic                       dec_illegal;
    logic [ENTRY_W-1:0]         head_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       illegal_seen_q, illegal_seen_d;

    // Decode sits in front of the FIFO so the core sees control bits with no extra latency.
    always_comb begin
        dec_cls     = classify_opcode(in_instr[6:0]);
        dec_ctrl    = class_ctrl(dec_cls);
        dec_illegal = (dec_cls == CLS_ILLEGAL);
        dec_instr   = in_instr;
        if (dec_illegal) begin
            dec_instr       = '0;
            dec_instr[31:0] = NOP_INSTR;
        end
        if (in_instr[11:7] == 5'd0) begin
            dec_ctrl.reg_write = 1'b0;
        end
    end

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    esm_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({dec_instr, dec_ctrl.alu_src, dec_ctrl.reg_write}),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_instr    = head_entry[ENTRY_W-1:DEC_CTRL_W];
    assign out_ALUSrc   = head_entry[1];
    assign out_RegWrite = head_entry[0];

    // Sticky until reset; a push dropped by flush was never accepted.
    always_comb begin
        illegal_seen_d = illegal_seen_q;
        if (push & ~flush & dec_illegal) begin
            illegal_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_esm_instr_feeder.sv
// tb/tb_esm_instr_feeder.sv - Directed self-checking bench for esm_instr_feeder
module tb_esm_instr_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_ALUSrc;
    logic        out_RegWrite;
    logic [2:0]  count;
    logic        illegal_seen;

    int errors = 0;
    int checks = 0;

    logic [31:0] fill_w [5];
    logic [31:0] thr_w  [8];

    always #5 clk = ~clk;

    esm_instr_feeder #(
        .Instr_word_size (32),
        .DEPTH           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_ALUSrc   (out_ALUSrc),
        .out_RegWrite (out_RegWrite),
        .count        (count),
        .illegal_seen (illegal_seen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] w, input logic alu, input logic rw);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".instr"}, out_instr, w);
        check({tag, ".alusrc"}, 32'(out_ALUSrc), 32'(alu));
        check({tag, ".regwrite"}, 32'(out_RegWrite), 32'(rw));
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fill_w[i] = 32'h0010_0093 + (32'(i) << 20);
        for (int k = 0; k < 8; k++) thr_w[k] = 32'h0000_0033 | (32'(k + 1) << 7);

        tick();
        check("rst.count", 32'(count), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.illegal", 32'(illegal_seen), 32'd0);
        check("rst.out_instr", out_instr, 32'd0);
        rst = 1'b0;
        tick();

        // rd=x0 suppresses RegWrite even for an R-type
        push_word(32'h0020_8033);
        check("add0.count", 32'(count), 32'd1);
        check_head("add0", 32'h0020_8033, 1'b0, 1'b0);
        push_word(32'h0020_81B3);
        check("add3.count", 32'(count), 32'd2);
        check_head("add0.held", 32'h0020_8033, 1'b0, 1'b0);
        pop_one();
        check_head("add3", 32'h0020_81B3, 1'b0, 1'b1);
        pop_one();
        check("add.empty", 32'(out_valid), 32'd0);

        push_word(32'h0030_A023);
        push_word(32'h0000_A183);
        push_word(32'h0020_8463);
        check("mix.count", 32'(count), 32'd3);
        check_head("sw", 32'h0030_A023, 1'b1, 1'b0);
        pop_one();
        check_head("lw", 32'h0000_A183, 1'b1, 1'b1);
        pop_one();
        check_head("beq", 32'h0020_8463, 1'b0, 1'b0);
        pop_one();
        check("mix.empty", 32'(count), 32'd0);

        for (int i = 0; i < 4; i++) push_word(fill_w[i]);
        check("full.count", 32'(count), 32'd4);
        check("full.in_ready", 32'(in_ready), 32'd0);
        push_word(fill_w[4]);
        check("full.refused", 32'(count), 32'd4);
        check_head("full.head", fill_w[0], 1'b1, 1'b1);
        // Pop while full: the simultaneous push must still be refused
        in_valid  = 1'b1;
        in_instr  = fill_w[4];
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full.pop_no_push", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), fill_w[i], 1'b1, 1'b1);
            pop_one();
        end
        check("drain.empty", 32'(out_valid), 32'd0);

        push_word(thr_w[0]);
        push_word(thr_w[1]);
        for (int k = 2; k < 8; k++) begin
            in_valid  = 1'b1;
            in_instr  = thr_w[k];
            out_ready = 1'b1;
            tick();
            check($sformatf("thr%0d.count", k), 32'(count), 32'd2);
            check($sformatf("thr%0d.head", k), out_instr, thr_w[k-1]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_head("thr.tail6", thr_w[6], 1'b0, 1'b1);
        pop_one();
        check_head("thr.tail7", thr_w[7], 1'b0, 1'b1);
        pop_one();
        check("thr.empty", 32'(out_valid), 32'd0);

        push_word(32'hFFFF_FFFF);
        check_head("illegal", 32'h0000_0013, 1'b1, 1'b0);
        check("illegal.flag", 32'(illegal_seen), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = thr_w[3];
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.count", 32'(count), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.illegal", 32'(illegal_seen), 32'd1);
        push_word(thr_w[5]);
        check("postflush.count", 32'(count), 32'd1);
        check_head("postflush", thr_w[5], 1'b0, 1'b1);

        push_word(fill_w[0]);
        push_word(fill_w[1]);
        check("midrst.pre", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.illegal", 32'(illegal_seen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        push_word(fill_w[2]);
        check_head("afterrst", fill_w[2], 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
